mem_access_unit: RTL and testbench

//  Memory-stage data-memory controller between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage data-memory controller: LB/LH/LW/LBU/LHU/SB/SH/SW on a byte-lane RAM.
// Each aligned op takes 1 (IDLE) + MEM_LATENCY (ACCESS) + 1 (DONE) cycles with stall held for all but DONE.
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_WORDS     = 1024,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mem_readM_i,
  input  logic                     mem_writeM_i,
  input  logic [2:0]               funct3M_i,
  input  logic [ADDRESS_WIDTH-1:0] alu_resultM_i,
  input  logic [DATA_WIDTH-1:0]    write_dataM_i,
  output logic [DATA_WIDTH-1:0]    read_dataM_o,
  output logic                     stallM_o,
  output logic                     misalignedM_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [31:0]      load_q;
  logic [31:0]      mem [MEM_WORDS];

  logic             req, is_store, misaligned, commit, start;
  logic             stall_c, mis_c;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata, rword, lane_data, ext_data;
  logic             unused_addr;

  // Upper address bits wrap around; they intentionally never reach the RAM.
  assign unused_addr = ^alu_resultM_i[ADDRESS_WIDTH-1:IDX_W+2];

  assign lane     = alu_resultM_i[1:0];
  assign idx      = alu_resultM_i[IDX_W+1:2];
  assign req      = mem_readM_i | mem_writeM_i;
  assign is_store = mem_writeM_i & ~mem_readM_i;
  assign commit   = (state == ACCESS) && (count == '0);
  assign start    = (state == IDLE) && req && !misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (funct3M_i[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      default: misaligned = |lane;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = 4'hF;
    wdata = write_dataM_i[31:0];
    case (funct3M_i[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{write_dataM_i[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{write_dataM_i[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = write_dataM_i[31:0];
      end
    endcase
  end

  assign rword     = mem[idx];
  assign lane_data = rword >> {lane, 3'b000};

  always_comb begin
    ext_data = rword;
    case (funct3M_i[1:0])
      2'b00:   ext_data = {{24{lane_data[7] & ~funct3M_i[2]}}, lane_data[7:0]};
      2'b01:   ext_data = {{16{lane_data[15] & ~funct3M_i[2]}}, lane_data[15:0]};
      default: ext_data = rword;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    mis_c     = 1'b0;
    case (state)
      IDLE: begin
        if (req && !misaligned) begin
          stall_c   = 1'b1;
          state_nxt = ACCESS;
        end else if (req) begin
          mis_c = 1'b1;
        end
      end
      ACCESS: begin
        stall_c = 1'b1;
        if (count == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count  <= '0;
      load_q <= '0;
    end else begin
      if (start) begin
        count <= CNT_W'(MEM_LATENCY - 1);
      end else if (state == ACCESS && count != '0) begin
        count <= count - 1'b1;
      end
      if (commit && mem_readM_i) load_q <= ext_data;
    end
  end

  // RAM is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (commit && is_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Reset is folded in so the stall releases the moment reset rises.
  assign stallM_o      = stall_c & ~rst_i;
  assign misalignedM_o = mis_c & ~rst_i;
  assign read_dataM_o  = DATA_WIDTH'(load_q);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed reference model checked every cycle.
module tb_mem_access_unit;

  localparam int L      = 2;
  localparam int NBYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        mem_readM_i, mem_writeM_i;
  logic [2:0]  funct3M_i;
  logic [31:0] alu_resultM_i, write_dataM_i;
  logic [31:0] read_dataM_o;
  logic        stallM_o, misalignedM_o;

  mem_access_unit #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .MEM_LATENCY(L)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_readM_i(mem_readM_i), .mem_writeM_i(mem_writeM_i),
    .funct3M_i(funct3M_i), .alu_resultM_i(alu_resultM_i), .write_dataM_i(write_dataM_i),
    .read_dataM_o(read_dataM_o), .stallM_o(stallM_o), .misalignedM_o(misalignedM_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram_m [NBYTES];
  logic        exp_stall, exp_mis;
  logic [31:0] exp_rd;
  int          op_scnt, op_mcnt;
  logic [31:0] op_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_stall", {31'b0, stallM_o}, {31'b0, exp_stall});
    chk("cyc_misaligned", {31'b0, misalignedM_o}, {31'b0, exp_mis});
    chk("cyc_read_data", read_dataM_o, exp_rd);
  end

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = ram_m[(a + i) % NBYTES];
    if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
    if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  // One instruction spends its whole life in M; entered just after a rising edge.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int   n   = nbytes(f3);
    logic mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    int   cycles;
    mem_readM_i = rd; mem_writeM_i = wr; funct3M_i = f3;
    alu_resultM_i = a; write_dataM_i = wd;
    op_scnt = 0; op_mcnt = 0;
    if ((rd || wr) && !mis) begin
      exp_stall = 1'b1; exp_mis = 1'b0; cycles = 1 + L;
    end else begin
      exp_stall = 1'b0; exp_mis = rd || wr; cycles = 1;
    end
    repeat (cycles) begin
      @(negedge clk);
      if (stallM_o) op_scnt++;
      if (misalignedM_o) op_mcnt++;
      op_rd = read_dataM_o;
      @(posedge clk); #1;
    end
    if ((rd || wr) && !mis) begin
      if (rd) exp_rd = model_load(f3, a);
      else for (int i = 0; i < n; i++) ram_m[(a + i) % NBYTES] = wd[i*8 +: 8];
      exp_stall = 1'b0; exp_mis = 1'b0;
      @(negedge clk);
      if (stallM_o) op_scnt++;
      op_rd = read_dataM_o;
      @(posedge clk); #1;
    end
    mem_readM_i = 1'b0; mem_writeM_i = 1'b0; exp_mis = 1'b0; exp_stall = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NBYTES; i++) ram_m[i] = 8'h00;
    rst_i = 1'b1; mem_readM_i = 1'b0; mem_writeM_i = 1'b0;
    funct3M_i = 3'b000; alu_resultM_i = '0; write_dataM_i = '0;
    exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_read_data", read_dataM_o, 32'h0);
    chk("reset_stall", {31'b0, stallM_o}, 32'h0);
    chk("reset_misaligned", {31'b0, misalignedM_o}, 32'h0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    do_op(0, 1, 3'b010, 32'h20, 32'h0);
    do_op(0, 1, 3'b010, 32'h0, 32'hCAFEF00D);

    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_stall_cycles", op_scnt, 3);
    do_op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("lw_stall_cycles", op_scnt, 3);
    chk("lw_10", op_rd, 32'hDEADBEEF);

    do_op(0, 1, 3'b000, 32'h13, 32'hFFFFFF80);
    do_op(1, 0, 3'b000, 32'h13, 32'h0);
    chk("lb_13", op_rd, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h13, 32'h0);
    chk("lbu_13", op_rd, 32'h00000080);
    do_op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("lw_after_sb", op_rd, 32'h80ADBEEF);

    do_op(0, 1, 3'b001, 32'h12, 32'h55558001);
    do_op(1, 0, 3'b001, 32'h12, 32'h0);
    chk("lh_12", op_rd, 32'hFFFF8001);
    do_op(1, 0, 3'b101, 32'h12, 32'h0);
    chk("lhu_12", op_rd, 32'h00008001);
    do_op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("lw_after_sh", op_rd, 32'h8001BEEF);
    do_op(1, 0, 3'b001, 32'h10, 32'h0);
    chk("lh_10", op_rd, 32'hFFFFBEEF);

    do_op(1, 0, 3'b010, 32'h11, 32'h0);
    chk("lw_mis_flag", op_mcnt, 1);
    chk("lw_mis_nostall", op_scnt, 0);
    chk("lw_mis_hold", op_rd, 32'hFFFFBEEF);
    do_op(0, 1, 3'b001, 32'h13, 32'h0000FFFF);
    chk("sh_mis_flag", op_mcnt, 1);
    chk("sh_mis_nostall", op_scnt, 0);
    do_op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("ram_after_mis", op_rd, 32'h8001BEEF);

    // Load and store both requested: load wins and RAM must stay put.
    do_op(1, 1, 3'b010, 32'h0, 32'h11111111);
    chk("rw_load_wins", op_rd, 32'hCAFEF00D);
    do_op(1, 0, 3'b010, 32'h0, 32'h0);
    chk("rw_store_suppressed", op_rd, 32'hCAFEF00D);

    mem_writeM_i = 1'b1; funct3M_i = 3'b010;
    alu_resultM_i = 32'h20; write_dataM_i = 32'h12345678;
    exp_stall = 1'b1;
    @(posedge clk); #2;
    rst_i = 1'b1; mem_writeM_i = 1'b0;
    exp_stall = 1'b0; exp_rd = '0;
    #1;
    chk("rst_abort_stall", {31'b0, stallM_o}, 32'h0);
    chk("rst_abort_read_data", read_dataM_o, 32'h0);
    @(negedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    do_op(1, 0, 3'b010, 32'h20, 32'h0);
    chk("lw_20_after_abort", op_rd, 32'h00000000);

    do_op(1, 0, 3'b010, 32'h10, 32'h0);
    chk("b2b_first_stall", op_scnt, 3);
    do_op(1, 0, 3'b010, 32'h2000, 32'h0);
    chk("b2b_second_stall", op_scnt, 3);
    chk("lw_wrap", op_rd, 32'hCAFEF00D);
    do_op(0, 0, 3'b000, 32'h10, 32'h5);
    chk("add_nostall", op_scnt, 0);
    chk("add_nomis", op_mcnt, 0);
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
